// File: rtl/spi_slave_sync_if.sv
// Core-side bundle of the SPI slave: RX/TX valid/ready handshakes,
// sticky error flags and the busy indication.
interface spi_slave_sync_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             rx_overrun;
  logic             tx_underrun;
  logic             clr_flags;
  logic             busy;

  // The SPI slave drives the status side of the bundle.
  modport slave (
    output rx_data, rx_valid, tx_ready, rx_overrun, tx_underrun, busy,
    input  rx_ready, tx_data, tx_valid, clr_flags
  );

  // The core consumes RX words and supplies TX words.
  modport master (
    input  rx_data, rx_valid, tx_ready, rx_overrun, tx_underrun, busy,
    output rx_ready, tx_data, tx_valid, clr_flags
  );
endinterface

// File: rtl/spi_slave_sync.sv
// Oversampling SPI slave. SCLK, CS_n and MOSI are synchronised into clk,
// edges are detected one register later, and words are exchanged with the
// core through one buffered RX word and one TX holding register.
module spi_slave_sync #(
  parameter int unsigned      WIDTH       = 8,
  parameter bit               CPOL        = 1'b0,
  parameter bit               CPHA        = 1'b0,
  parameter bit               MSB_FIRST   = 1'b1,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_IDLE     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              miso_oe,
  spi_slave_sync_if.slave   core
);

  localparam int unsigned     CW        = $clog2(WIDTH);
  localparam int unsigned     FW        = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [FW-1:0]   FLUSH_CYC = FW'(SYNC_STAGES + 1);

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    return MSB_FIRST ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_n_prev_q, cs_n_prev_d;
  logic [FW-1:0]          flush_q, flush_d;
  logic                   armed_q, armed_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0]       tx_sr_q, tx_sr_d;
  logic                   miso_q, miso_d;
  logic                   oe_q, oe_d;
  logic                   busy_q, busy_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   ovr_q, ovr_d;
  logic                   udr_q, udr_d;

  logic sclk_s, cs_n_s, mosi_s, sel_s;
  logic cs_assert_s, cs_deassert_s, lead_s, trail_s;
  logic sample_s, shift_edge_s, load_s, shift_s;
  logic [WIDTH-1:0] tx_word_s, tx_next_s, rx_word_s;

  // Synchronised pin views and edge/load-point decode.
  always_comb begin
    sclk_s        = sclk_sync_q[SYNC_STAGES-1];
    cs_n_s        = cs_sync_q[SYNC_STAGES-1];
    mosi_s        = mosi_sync_q[SYNC_STAGES-1];
    // Traffic is honoured only after a deassert has been seen since reset.
    sel_s         = armed_q && !cs_n_s;
    cs_assert_s   = armed_q && cs_n_prev_q && !cs_n_s;
    cs_deassert_s = armed_q && !cs_n_prev_q && cs_n_s;
    lead_s        = sel_s && (sclk_s != CPOL) && (sclk_prev_q == CPOL);
    trail_s       = sel_s && (sclk_s == CPOL) && (sclk_prev_q != CPOL);
    sample_s      = CPHA ? trail_s : lead_s;
    shift_edge_s  = CPHA ? lead_s : trail_s;
    // CPHA=0 loads at CS assert and at the trailing edge after a wrap;
    // CPHA=1 loads at the leading edge of bit 0.
    load_s        = CPHA ? (lead_s && (bit_cnt_q == '0))
                         : (cs_assert_s || (trail_s && (bit_cnt_q == '0)));
    shift_s       = shift_edge_s && !load_s;
  end

  // Next-state computation for synchronisers, shift paths and handshakes.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
    sclk_prev_d = sclk_s;
    cs_n_prev_d = cs_n_s;
    flush_d     = (flush_q == '0) ? flush_q : flush_q - FW'(1);
    armed_d     = armed_q || ((flush_q == '0) && cs_n_s);
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    oe_d        = sel_s;
    busy_d      = sel_s;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    hold_d      = hold_q;
    tx_ready_d  = tx_ready_q;
    ovr_d       = ovr_q;
    udr_d       = udr_q;
    tx_word_s   = TX_IDLE;
    tx_next_s   = shift_out(tx_sr_q);
    rx_word_s   = shift_in(rx_sr_q, mosi_s);

    // Clear first so that a same-cycle set event wins.
    if (core.clr_flags) begin
      ovr_d = 1'b0;
      udr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
      udr_d = udr_q;
    end

    // Transmit path: holding state is taken before any same-cycle write.
    if (load_s) begin
      if (!tx_ready_q) begin
        tx_word_s  = hold_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_word_s  = TX_IDLE;
        udr_d      = 1'b1;
      end
      tx_sr_d = tx_word_s;
      miso_d  = first_bit(tx_word_s);
    end else if (shift_s) begin
      tx_sr_d = tx_next_s;
      miso_d  = first_bit(tx_next_s);
    end else begin
      tx_sr_d = tx_sr_q;
    end

    // A write accepted in a load cycle is kept for the following word.
    if (core.tx_valid && tx_ready_q) begin
      hold_d     = core.tx_data;
      tx_ready_d = 1'b0;
    end else begin
      hold_d     = hold_q;
    end

    if (rx_valid_q && core.rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    // Receive path; CS edges discard any partial word.
    if (cs_assert_s || cs_deassert_s) begin
      bit_cnt_d = '0;
      rx_sr_d   = '0;
    end else if (sample_s) begin
      rx_sr_d = rx_word_s;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        if (!rx_valid_q || core.rx_ready) begin
          rx_data_d  = rx_word_s;
          rx_valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // State register with synchronous reset to idle pin levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sclk_prev_q <= CPOL;
      cs_n_prev_q <= 1'b1;
      flush_q     <= FLUSH_CYC;
      armed_q     <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= TX_IDLE;
      miso_q      <= first_bit(TX_IDLE);
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      hold_q      <= '0;
      tx_ready_q  <= 1'b1;
      ovr_q       <= 1'b0;
      udr_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_n_prev_q <= cs_n_prev_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      tx_ready_q  <= tx_ready_d;
      ovr_q       <= ovr_d;
      udr_q       <= udr_d;
    end
  end

  assign miso_out         = miso_q;
  assign miso_oe          = oe_q;
  assign core.rx_data     = rx_data_q;
  assign core.rx_valid    = rx_valid_q;
  assign core.tx_ready    = tx_ready_q;
  assign core.rx_overrun  = ovr_q;
  assign core.tx_underrun = udr_q;
  assign core.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync: three instances cover mode 0 (with
// TX_IDLE=0xFF), mode 3 and a 16-bit LSB-first CPHA=1 configuration.
module tb_spi_slave_sync;
  localparam int H = 6;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sclk_raw;
  logic       mosi;
  logic [2:0] cs_n;
  logic       miso0, miso1, miso2;
  logic       oe0, oe1, oe2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  spi_slave_sync_if #(.WIDTH(8))  if0 ();
  spi_slave_sync_if #(.WIDTH(8))  if1 ();
  spi_slave_sync_if #(.WIDTH(16)) if2 ();

  spi_slave_sync #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                   .SYNC_STAGES(2), .TX_IDLE(8'hFF)) u0 (
    .clk(clk), .rst(rst), .sclk_in(sclk_raw), .cs_n_in(cs_n[0]), .mosi_in(mosi),
    .miso_out(miso0), .miso_oe(oe0), .core(if0));

  spi_slave_sync #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1),
                   .SYNC_STAGES(2), .TX_IDLE(8'h00)) u1 (
    .clk(clk), .rst(rst), .sclk_in(~sclk_raw), .cs_n_in(cs_n[1]), .mosi_in(mosi),
    .miso_out(miso1), .miso_oe(oe1), .core(if1));

  spi_slave_sync #(.WIDTH(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0),
                   .SYNC_STAGES(2), .TX_IDLE(16'h0000)) u2 (
    .clk(clk), .rst(rst), .sclk_in(sclk_raw), .cs_n_in(cs_n[2]), .mosi_in(mosi),
    .miso_out(miso2), .miso_oe(oe2), .core(if2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RX scoreboard monitors: every accepted RX handshake pops one expected word.
  always @(negedge clk) begin
    if (!rst && if0.rx_valid && if0.rx_ready) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx0_unexpected: got %h expected none", if0.rx_data);
      end else chk("rx0_word", {24'd0, if0.rx_data}, exp_q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && if1.rx_valid && if1.rx_ready) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx1_unexpected: got %h expected none", if1.rx_data);
      end else chk("rx1_word", {24'd0, if1.rx_data}, exp_q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && if2.rx_valid && if2.rx_ready) begin
      if (exp_q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx2_unexpected: got %h expected none", if2.rx_data);
      end else chk("rx2_word", {16'd0, if2.rx_data}, exp_q2.pop_front());
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic get_miso(input int d, output logic b);
    case (d)
      0:       b = miso0;
      1:       b = miso1;
      default: b = miso2;
    endcase
  endtask

  // SPI master: drives MOSI and samples MISO at the mode-appropriate instants.
  task automatic xfer(input int d, input int nbits, input logic [31:0] mo,
                      output logic [31:0] mi);
    int   w;
    bit   cpha;
    bit   msb;
    int   idx;
    logic b;
    case (d)
      0:       begin w = 8;  cpha = 1'b0; msb = 1'b1; end
      1:       begin w = 8;  cpha = 1'b1; msb = 1'b1; end
      default: begin w = 16; cpha = 1'b1; msb = 1'b0; end
    endcase
    mi = 32'd0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? (w - 1 - i) : i;
      if (!cpha) begin
        mosi = mo[idx];
        wclk(H);
        get_miso(d, b);
        mi[idx] = b;
        sclk_raw = 1'b1;
        wclk(H);
        sclk_raw = 1'b0;
      end else begin
        sclk_raw = 1'b1;
        mosi = mo[idx];
        wclk(H);
        get_miso(d, b);
        mi[idx] = b;
        sclk_raw = 1'b0;
        wclk(H);
      end
    end
    if (!cpha) wclk(H);
  endtask

  task automatic frame_start(input int d);
    cs_n[d] = 1'b0;
    wclk(H);
  endtask

  task automatic frame_end(input int d);
    cs_n[d] = 1'b1;
    wclk(H);
  endtask

  task automatic tx_write(input int d, input logic [15:0] v);
    case (d)
      0:       begin if0.tx_data = v[7:0]; if0.tx_valid = 1'b1; end
      1:       begin if1.tx_data = v[7:0]; if1.tx_valid = 1'b1; end
      default: begin if2.tx_data = v;      if2.tx_valid = 1'b1; end
    endcase
    wclk(1);
    if0.tx_valid = 1'b0;
    if1.tx_valid = 1'b0;
    if2.tx_valid = 1'b0;
  endtask

  task automatic clr0();
    if0.clr_flags = 1'b1;
    wclk(1);
    if0.clr_flags = 1'b0;
    wclk(1);
  endtask

  logic [31:0] mi_a, mi_b;
  int          k;

  initial begin
    rst = 1'b1; sclk_raw = 1'b0; mosi = 1'b0; cs_n = 3'b111;
    if0.rx_ready = 1'b1; if0.tx_valid = 1'b0; if0.tx_data = 8'h00;  if0.clr_flags = 1'b0;
    if1.rx_ready = 1'b1; if1.tx_valid = 1'b0; if1.tx_data = 8'h00;  if1.clr_flags = 1'b0;
    if2.rx_ready = 1'b1; if2.tx_valid = 1'b0; if2.tx_data = 16'h0000; if2.clr_flags = 1'b0;
    wclk(3);
    rst = 1'b0;
    wclk(1);

    // Reset state.
    chk("rst_tx_ready",  {31'd0, if0.tx_ready},    32'd1);
    chk("rst_rx_valid",  {31'd0, if0.rx_valid},    32'd0);
    chk("rst_rx_data",   {24'd0, if0.rx_data},     32'd0);
    chk("rst_flags",     {30'd0, if0.rx_overrun, if0.tx_underrun}, 32'd0);
    chk("rst_busy_oe",   {30'd0, if0.busy, oe0},   32'd0);
    chk("rst_miso0",     {31'd0, miso0},           32'd1);
    chk("rst_miso1",     {31'd0, miso1},           32'd0);
    wclk(8);

    // Mode 0: preload 0xA5, master sends 0x3C.
    tx_write(0, 16'h00A5);
    chk("m0_tx_ready_low", {31'd0, if0.tx_ready}, 32'd0);
    exp_q0.push_back(32'h3C);
    frame_start(0);
    xfer(0, 8, 32'h3C, mi_a);
    frame_end(0);
    chk("m0_miso_word",  mi_a, 32'hA5);
    chk("m0_tx_ready",   {31'd0, if0.tx_ready}, 32'd1);
    // The trailing edge after bit 7 is a load point with an empty register.
    chk("m0_underrun",   {31'd0, if0.tx_underrun}, 32'd1);
    chk("m0_overrun",    {31'd0, if0.rx_overrun}, 32'd0);
    clr0();
    chk("m0_clr",        {31'd0, if0.tx_underrun}, 32'd0);

    // Overrun: rx_ready held low across two words.
    if0.rx_ready = 1'b0;
    exp_q0.push_back(32'h11);
    frame_start(0);
    xfer(0, 8, 32'h11, mi_a);
    xfer(0, 8, 32'h22, mi_a);
    frame_end(0);
    chk("ovr_rx_data",   {24'd0, if0.rx_data}, 32'h11);
    chk("ovr_rx_valid",  {31'd0, if0.rx_valid}, 32'd1);
    chk("ovr_flag",      {31'd0, if0.rx_overrun}, 32'd1);
    clr0();
    chk("ovr_clr",       {31'd0, if0.rx_overrun}, 32'd0);
    if0.rx_ready = 1'b1;
    wclk(3);
    chk("ovr_drained",   {31'd0, if0.rx_valid}, 32'd0);

    // Underrun: no TX write, TX_IDLE=0xFF goes out.
    exp_q0.push_back(32'h00);
    frame_start(0);
    xfer(0, 8, 32'h00, mi_a);
    frame_end(0);
    chk("udr_miso_word", mi_a, 32'hFF);
    chk("udr_flag",      {31'd0, if0.tx_underrun}, 32'd1);
    clr0();

    // Abort after 5 bits of 0xAA, then a full 0x55 frame.
    frame_start(0);
    xfer(0, 5, 32'hAA, mi_a);
    chk("abt_busy_sel",  {30'd0, if0.busy, oe0}, 32'd3);
    frame_end(0);
    chk("abt_oe_idle",   {30'd0, if0.busy, oe0}, 32'd0);
    chk("abt_no_valid",  {31'd0, if0.rx_valid}, 32'd0);
    exp_q0.push_back(32'h55);
    frame_start(0);
    xfer(0, 8, 32'h55, mi_a);
    frame_end(0);
    chk("abt_rx_data",   {24'd0, if0.rx_data}, 32'h55);

    // Mode 3: two back-to-back words, second TX word written mid-word.
    tx_write(1, 16'h00F0);
    exp_q1.push_back(32'h12);
    exp_q1.push_back(32'h34);
    frame_start(1);
    fork
      begin
        xfer(1, 8, 32'h12, mi_a);
        xfer(1, 8, 32'h34, mi_b);
      end
      begin
        k = 0;
        while (if1.tx_ready !== 1'b1 && k < 200) begin
          wclk(1);
          k++;
        end
        chk("m3_tx_ready_wait", {31'd0, (k < 200)}, 32'd1);
        tx_write(1, 16'h000F);
      end
    join
    frame_end(1);
    chk("m3_miso_w0",    mi_a, 32'hF0);
    chk("m3_miso_w1",    mi_b, 32'h0F);
    chk("m3_flags",      {30'd0, if1.rx_overrun, if1.tx_underrun}, 32'd0);

    // WIDTH=16, LSB-first, CPHA=1.
    tx_write(2, 16'h1234);
    exp_q2.push_back(32'hBEEF);
    frame_start(2);
    xfer(2, 16, 32'hBEEF, mi_a);
    frame_end(2);
    chk("w16_miso_word", mi_a, 32'h1234);
    chk("w16_rx_data",   {16'd0, if2.rx_data}, 32'hBEEF);

    // All expected RX words must have been consumed.
    k = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && k < 100) begin
      wclk(1);
      k++;
    end
    chk("queues_empty", exp_q0.size() + exp_q1.size() + exp_q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Parametrised SPI slave that oversamples SCLK, CS_n and MOSI in the system clock domain. There is no second clock domain.
- Supports all four SPI modes through parameters and a configurable word width.
- Exchanges full-duplex words with the core through valid/ready handshakes, with one buffered RX word and one TX holding register.
- Sits between the uio pins and the QOA decode core. Replaces the single-byte mode-0 echo interface.

Parameters:
WIDTH, 8, bits per SPI word (4..32)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge
MSB_FIRST, 1, bit order on both MOSI and MISO
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
TX_IDLE, 0, word sent when the TX holding register is empty at a load point

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sclk_in  in  1  SPI clock pin (asynchronous)
cs_n_in  in  1  SPI chip select, active-low (asynchronous)
mosi_in  in  1  SPI data in (asynchronous)
miso_out  out  1  SPI data out
miso_oe  out  1  output enable for miso pad; high only while selected
rx_data  out  WIDTH  received word
rx_valid  out  1  rx_data holds an unread word
rx_ready  in  1  core accepts rx_data
tx_data  in  WIDTH  word to transmit
tx_valid  in  1  tx_data offered
tx_ready  out  1  TX holding register empty
rx_overrun  out  1  sticky: a word was dropped because rx_valid was still set
tx_underrun  out  1  sticky: TX_IDLE was sent because the holding register was empty
clr_flags  in  1  clears both sticky flags
busy  out  1  synchronised CS is active

Behaviour:
- Reset: all outputs 0 except tx_ready=1. miso_out=TX_IDLE first bit. Bit counter=0. Synchronisers are filled with idle levels (CS_n=1, SCLK=CPOL).
- Input path: each pin passes through SYNC_STAGES flip-flops. One extra register provides edge detection.
- Leading edge = synchronised SCLK leaving CPOL. Trailing edge = synchronised SCLK returning to CPOL.
- Edges are honoured only while selected. Latency from pin to internal edge event is SYNC_STAGES+1 clk.
- Legal SCLK: high and low phases each >= SYNC_STAGES+2 clk.
- Load point (shift register takes the next TX word):
  - CPHA=0: on the CS-assert event, and at the trailing edge that follows the sample of bit WIDTH-1.
  - CPHA=1: at the leading edge of bit 0.
- At a load point:
  - If the holding register is full: load it, set tx_ready=1 the next cycle.
  - If it is empty: load TX_IDLE and set tx_underrun.
  - The holding state is taken before any same-cycle write. A write in that cycle is kept for the next word.
- Shift edge drives the next bit onto miso_out, registered, 1 clk after the event.
- Sample edge captures the synchronised MOSI and increments the bit counter.
- Word completion: on the sample that fills bit WIDTH-1, the counter wraps to 0.
  - If rx_valid=0, or rx_ready=1 in the same cycle: rx_data takes the word and rx_valid=1 the next clk.
  - Otherwise the new word is dropped, rx_data is unchanged, and rx_overrun is set.
- RX handshake: rx_valid stays high until a cycle with rx_ready=1, then clears the next clk.
- TX handshake: tx_valid&&tx_ready writes the holding register; tx_ready=0 the next clk.
- Flags: clr_flags clears both flags. A set event in the same cycle wins, and the flag stays 1.
- Abort: CS deasserted mid-word.
  - The counter resets to 0 and partial RX bits are discarded; no rx_valid or overrun.
  - The word already loaded for TX is consumed and not retransmitted.
  - miso_oe=0 and busy=0 one clk after the CS-deassert event.
- Back-to-back words within one CS frame: no gap is required. Continuous streaming works when the core services each handshake within one word time.
- rst in mid-frame: reset state is applied immediately. Traffic is ignored until CS is next deasserted and then reasserted.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0, WIDTH=8):
  - Stimulus: preload tx 0xA5; master sends 0x3C in one 8-bit frame.
  - Required: rx_data=0x3C, rx_valid pulse; MISO sampled by master = 0xA5; tx_ready back to 1.
- Mode 3 (CPOL=1, CPHA=1):
  - Stimulus: two back-to-back words 0x12, 0x34 in one frame; core preloads 0xF0, then 0x0F during the first word.
  - Required: rx sees 0x12 then 0x34; master sees 0xF0 then 0x0F; no flags set.
- Overrun:
  - Stimulus: rx_ready held 0; master sends 0x11 then 0x22.
  - Required: rx_data stays 0x11; rx_overrun=1; clr_flags clears it.
- Underrun:
  - Stimulus: TX_IDLE=0xFF; no tx write; master clocks 8 bits.
  - Required: MISO=0xFF; tx_underrun=1.
- Abort:
  - Stimulus: CS deasserted after 5 bits of 0xAA; new frame sends 0x55.
  - Required: no rx_valid for the partial word; rx_data=0x55; miso_oe=0 between frames.
- WIDTH=16, LSB-first:
  - Stimulus: master sends 0xBEEF LSB-first.
  - Required: rx_data=0xBEEF.
